// File: rtl/brique_pkg.sv
// Shared widths, idle code and state type for the brick-state keeper.
package brique_pkg;

    localparam int unsigned ADR_W = 9;
    localparam logic [ADR_W-1:0] ADR_IDLE = 9'h1FF;

    typedef enum logic {
        IDLE = 1'b0,
        INIT = 1'b1
    } etat_t;

endpackage

// File: rtl/brique_bitmap.sv
// One alive bit per brick: one write port, one registered read port for the
// renderer and one combinational probe used to test a brick before killing it.
module brique_bitmap
    import brique_pkg::*;
#(
    parameter int unsigned NB_BRIQUES = 400
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we,
    input  logic [ADR_W-1:0] wadr,
    input  logic             wdata,
    input  logic [ADR_W-1:0] rd_adr,
    output logic             rd_data,
    input  logic [ADR_W-1:0] chk_adr,
    output logic             chk_data_c
);

    localparam int unsigned      DEPTH = 1 << ADR_W;
    localparam logic [ADR_W-1:0] NB_C  = ADR_W'(NB_BRIQUES);

    logic [NB_BRIQUES-1:0] mem;
    logic [DEPTH-1:0]      mem_pad;

    // Per-bit storage so every index is a constant and unused indices cost nothing.
    for (genvar g = 0; g < NB_BRIQUES; g++) begin : g_bit
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                mem[g] <= 1'b0;
            end else if (we && (wadr == ADR_W'(g))) begin
                mem[g] <= wdata;
            end
        end
    end

    // Zero padding up to the full address space makes out-of-range reads 0.
    assign mem_pad    = DEPTH'(mem);
    assign chk_data_c = mem_pad[chk_adr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= 1'b0;
        end else begin
            rd_data <= (rd_adr < NB_C) ? mem_pad[rd_adr] : 1'b0;
        end
    end

endmodule

// File: rtl/brique_etat.sv
// Brick-state keeper: turns brick indices from software into single kills,
// tracks remaining bricks and sweeps the field alive on a new level.
module brique_etat
    import brique_pkg::*;
#(
    parameter int unsigned NB_BRIQUES = 400
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [ADR_W-1:0] adr_brique,
    input  logic             init_niveau,
    input  logic [ADR_W-1:0] rd_adr,
    output logic             rd_vivante,
    output logic [ADR_W-1:0] nb_restantes,
    output logic             occupe,
    output logic             brique_cassee,
    output logic             niveau_fini
);

    localparam logic [ADR_W-1:0] NB_C   = ADR_W'(NB_BRIQUES);
    localparam logic [ADR_W-1:0] LAST_C = ADR_W'(NB_BRIQUES - 1);

    etat_t            etat, etat_n;
    logic [ADR_W-1:0] adr_prev;
    logic [ADR_W-1:0] pend_adr, pend_adr_n;
    logic             pend_vld, pend_vld_n;
    logic [ADR_W-1:0] idx, idx_n;
    logic [ADR_W-1:0] cnt_n;
    logic             occupe_n, cassee_n, fini_n;
    logic             we_c, wdata_c, vivante_c, capture_c, flush_c;
    logic [ADR_W-1:0] wadr_c;

    brique_bitmap #(
        .NB_BRIQUES(NB_BRIQUES)
    ) u_bitmap (
        .clk       (clk),
        .reset_n   (reset_n),
        .we        (we_c),
        .wadr      (wadr_c),
        .wdata     (wdata_c),
        .rd_adr    (rd_adr),
        .rd_data   (rd_vivante),
        .chk_adr   (pend_adr),
        .chk_data_c(vivante_c)
    );

    // A new, non-idle value on the level-held PIO is one kill request.
    assign capture_c = (adr_brique != adr_prev) && (adr_brique != ADR_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            etat          <= IDLE;
            adr_prev      <= '0;
            pend_vld      <= 1'b0;
            pend_adr      <= '0;
            idx           <= '0;
            nb_restantes  <= '0;
            occupe        <= 1'b0;
            brique_cassee <= 1'b0;
            niveau_fini   <= 1'b0;
        end else begin
            etat          <= etat_n;
            adr_prev      <= adr_brique;
            pend_vld      <= pend_vld_n;
            pend_adr      <= pend_adr_n;
            idx           <= idx_n;
            nb_restantes  <= cnt_n;
            occupe        <= occupe_n;
            brique_cassee <= cassee_n;
            niveau_fini   <= fini_n;
        end
    end

    always_comb begin
        etat_n     = etat;
        idx_n      = idx;
        cnt_n      = nb_restantes;
        occupe_n   = occupe;
        cassee_n   = 1'b0;
        fini_n     = 1'b0;
        pend_vld_n = pend_vld;
        pend_adr_n = pend_adr;
        we_c       = 1'b0;
        wadr_c     = pend_adr;
        wdata_c    = 1'b0;
        flush_c    = 1'b0;

        unique case (etat)
            IDLE: begin
                if (init_niveau) begin
                    etat_n   = INIT;
                    idx_n    = '0;
                    cnt_n    = '0;
                    occupe_n = 1'b1;
                    flush_c  = 1'b1;
                end else if (pend_vld) begin
                    pend_vld_n = 1'b0;
                    if ((pend_adr < NB_C) && vivante_c && (nb_restantes != '0)) begin
                        we_c     = 1'b1;
                        cnt_n    = nb_restantes - ADR_W'(1);
                        cassee_n = 1'b1;
                        fini_n   = (nb_restantes == ADR_W'(1));
                    end
                end
            end
            INIT: begin
                we_c    = 1'b1;
                wadr_c  = idx;
                wdata_c = 1'b1;
                idx_n   = idx + ADR_W'(1);
                if (idx == LAST_C) begin
                    etat_n   = IDLE;
                    cnt_n    = NB_C;
                    occupe_n = 1'b0;
                end
            end
            default: etat_n = IDLE;
        endcase

        // Starting a level discards any kill, including one arriving this cycle.
        if (flush_c) begin
            pend_vld_n = 1'b0;
        end else if (capture_c) begin
            pend_vld_n = 1'b1;
            pend_adr_n = adr_brique;
        end
    end

endmodule

// File: tb/tb_brique_etat.sv
// Randomised bench for brique_etat against an array-based model of the brick field.
module tb_brique_etat;

    localparam int NB = 400;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [8:0] adr_brique;
    logic       init_niveau;
    logic [8:0] rd_adr;
    logic       rd_vivante;
    logic [8:0] nb_restantes;
    logic       occupe;
    logic       brique_cassee;
    logic       niveau_fini;

    always #5 clk = ~clk;

    brique_etat #(.NB_BRIQUES(NB)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .adr_brique   (adr_brique),
        .init_niveau  (init_niveau),
        .rd_adr       (rd_adr),
        .rd_vivante   (rd_vivante),
        .nb_restantes (nb_restantes),
        .occupe       (occupe),
        .brique_cassee(brique_cassee),
        .niveau_fini  (niveau_fini)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int fini_seen = 0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // Model state: field contents, sweep progress, one pending request.
    bit   alive_m [NB];
    int   sweep_left;
    bit   pend_v;
    int   pend_a;
    logic [8:0] prev_m;
    int   e_rd, e_cnt, e_occ, e_cas, e_fin;

    function automatic int pop();
        int s = 0;
        for (int j = 0; j < NB; j++) s += int'(alive_m[j]);
        return s;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < NB; j++) alive_m[j] = 1'b0;
        sweep_left = 0; pend_v = 1'b0; pend_a = 0; prev_m = 9'd0;
        e_rd = 0; e_cnt = 0; e_occ = 0; e_cas = 0; e_fin = 0;
    endtask

    task automatic model_step();
        bit cap;
        int a;
        a     = int'(adr_brique);
        e_rd  = (int'(rd_adr) < NB) ? int'(alive_m[int'(rd_adr)]) : 0;
        e_cas = 0;
        e_fin = 0;
        cap   = (adr_brique != prev_m) && (adr_brique != 9'h1FF);
        prev_m = adr_brique;
        if (sweep_left > 0) begin
            alive_m[NB - sweep_left] = 1'b1;
            sweep_left--;
        end else if (init_niveau) begin
            sweep_left = NB;
            pend_v = 1'b0;
            cap = 1'b0;
        end else if (pend_v) begin
            pend_v = 1'b0;
            if (pend_a < NB && alive_m[pend_a]) begin
                alive_m[pend_a] = 1'b0;
                e_cas = 1;
                e_fin = (pop() == 0) ? 1 : 0;
            end
        end
        if (cap) begin
            pend_v = 1'b1;
            pend_a = a;
        end
        e_occ = (sweep_left > 0) ? 1 : 0;
        e_cnt = (sweep_left > 0) ? 0 : pop();
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    // Single compare process: every output against the model every cycle.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("rd_vivante", int'(rd_vivante), e_rd);
            check("nb_restantes", int'(nb_restantes), e_cnt);
            check("occupe", int'(occupe), e_occ);
            check("brique_cassee", int'(brique_cassee), e_cas);
            check("niveau_fini", int'(niveau_fini), e_fin);
            if (niveau_fini) fini_seen++;
        end
    end

    task automatic wait_idle(input string nm, output int cyc);
        cyc = 0;
        while (occupe && cyc < 600) begin
            @(negedge clk);
            cyc++;
        end
        check(nm, int'(occupe), 0);
    endtask

    task automatic pulse_init();
        init_niveau = 1'b1;
        @(negedge clk);
        init_niveau = 1'b0;
    endtask

    int cyc;
    int ones;
    int perm [NB];

    initial begin
        reset_n = 1'b0; init_niveau = 1'b0; adr_brique = 9'h1FF; rd_adr = 9'd0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        reset_n = 1'b1;
        @(negedge clk);
        check("reset nb_restantes", int'(nb_restantes), 0);
        check("reset occupe", int'(occupe), 0);

        // Level init: occupe for exactly NB cycles, then full count.
        pulse_init();
        wait_idle("init1 timeout", cyc);
        check("occupe cycles", cyc, NB);
        check("count after init", int'(nb_restantes), 400);

        for (int r = 0; r <= NB; r++) begin
            rd_adr = 9'(r);
            @(negedge clk);
            if (r == 0)   check("rd 0 alive", int'(rd_vivante), 1);
            if (r == 399) check("rd 399 alive", int'(rd_vivante), 1);
            if (r == 400) check("rd 400 dead", int'(rd_vivante), 0);
        end

        // Single kill with exact pulse timing.
        adr_brique = 9'd5;
        @(negedge clk);
        check("kill5 no early pulse", int'(brique_cassee), 0);
        @(negedge clk);
        check("kill5 pulse", int'(brique_cassee), 1);
        check("kill5 count", int'(nb_restantes), 399);
        rd_adr = 9'd5;
        @(negedge clk);
        check("kill5 single pulse", int'(brique_cassee), 0);
        check("brick5 dead", int'(rd_vivante), 0);

        // Repeat kill of a dead brick, then an out-of-range index.
        adr_brique = 9'h1FF; @(negedge clk);
        adr_brique = 9'd5;   repeat (3) @(negedge clk);
        check("rekill5 count", int'(nb_restantes), 399);
        adr_brique = 9'd450; repeat (3) @(negedge clk);
        check("kill450 count", int'(nb_restantes), 399);

        // Kill issued during the sweep lands right after it.
        adr_brique = 9'h1FF; @(negedge clk);
        pulse_init();
        repeat (100) @(negedge clk);
        adr_brique = 9'd7;
        wait_idle("init2 timeout", cyc);
        @(negedge clk);
        check("kill during init", int'(nb_restantes), 399);
        rd_adr = 9'd7;
        @(negedge clk);
        check("brick7 dead", int'(rd_vivante), 0);

        // Kill in the same cycle as init is flushed.
        adr_brique = 9'h1FF; @(negedge clk);
        adr_brique = 9'd9;
        pulse_init();
        wait_idle("init3 timeout", cyc);
        repeat (2) @(negedge clk);
        check("flushed kill count", int'(nb_restantes), 400);

        // Asynchronous reset in the middle of a sweep.
        adr_brique = 9'h1FF;
        pulse_init();
        repeat (200) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midreset occupe", int'(occupe), 0);
        check("midreset count", int'(nb_restantes), 0);
        check("midreset rd", int'(rd_vivante), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        ones = 0;
        for (int r = 0; r < 512; r++) begin
            rd_adr = 9'(r);
            @(negedge clk);
            ones += int'(rd_vivante);
        end
        check("field dead after reset", ones, 0);

        // Random traffic.
        pulse_init();
        for (int t = 0; t < 3000; t++) begin
            adr_brique  = ($urandom_range(0, 1) == 0) ? 9'h1FF : 9'($urandom_range(0, 460));
            init_niveau = ($urandom_range(0, 299) == 0);
            rd_adr      = 9'($urandom_range(0, 511));
            @(negedge clk);
        end
        init_niveau = 1'b0;
        adr_brique = 9'h1FF;
        repeat (2) @(negedge clk);
        wait_idle("random timeout", cyc);

        // Clear the whole level in random order.
        pulse_init();
        wait_idle("final init timeout", cyc);
        for (int j = 0; j < NB; j++) perm[j] = j;
        for (int j = NB - 1; j > 0; j--) begin
            int k, tmp;
            k = int'($urandom_range(0, j));
            tmp = perm[j]; perm[j] = perm[k]; perm[k] = tmp;
        end
        fini_seen = 0;
        for (int j = 0; j < NB; j++) begin
            adr_brique = 9'(perm[j]);
            rd_adr     = 9'($urandom_range(0, 511));
            @(negedge clk);
            adr_brique = 9'h1FF;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("final count", int'(nb_restantes), 0);
        check("niveau_fini pulses", fini_seen, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/brique_etat.md
# brique_etat

Brick-state keeper for the casse-brique game, directly downstream of the Nios brick-address output PIO. It turns each new 9-bit brick index written by software into a single "kill" of that brick. It keeps one alive bit per brick and the count of remaining bricks, and serves alive bits to the VGA renderer through a synchronous read port. It also sweeps the whole field alive when a new level starts.

## Interface
- NB_BRIQUES, default 400: number of bricks (1..511); valid indices are 0..NB_BRIQUES-1.
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- adr_brique  in  9  PIO out_port, level-held brick index; 9'h1FF = idle
- init_niveau  in  1  single-cycle pulse that starts the level-init sweep
- rd_adr  in  9  renderer query index
- rd_vivante  out  1  alive bit of rd_adr, registered
- nb_restantes  out  9  bricks still alive
- occupe  out  1  high while the init sweep runs
- brique_cassee  out  1  1-cycle pulse when a kill takes effect
- niveau_fini  out  1  1-cycle pulse when nb_restantes goes 1 -> 0

## Operation
- Reset values: all alive bits 0, nb_restantes 0, rd_vivante 0, occupe 0, brique_cassee 0, niveau_fini 0, state IDLE, adr_prev 0, no kill pending.
- Command detection:
  - adr_prev registers adr_brique every cycle.
  - A kill request is captured into a single-entry pending register when adr_brique != adr_prev and adr_brique != 9'h1FF.
  - To kill the same brick twice, software writes 9'h1FF in between.
  - A new request overwrites an unconsumed pending one.
- States:
  - IDLE: if init_niveau, go to INIT. Init has priority over a pending kill and flushes it. Otherwise, if a kill is pending, apply it.
  - INIT: counter i runs 0..NB_BRIQUES-1, setting one bit per cycle. After the last bit, go to IDLE.
- INIT entry:
  - nb_restantes <= 0, occupe <= 1.
  - At the last write, nb_restantes <= NB_BRIQUES and occupe <= 0.
  - init_niveau during INIT is ignored.
  - Kill requests during INIT are held pending and applied on the first IDLE cycle.
- Kill apply:
  - Index >= NB_BRIQUES: dropped silently, no pulse.
  - Bit already 0: pending cleared, no count change, no pulse.
  - Otherwise: clear the bit, nb_restantes - 1, brique_cassee pulse. If the old count was 1, niveau_fini pulses in the same cycle.
- nb_restantes never underflows or exceeds NB_BRIQUES.
- Read port: rd_vivante <= (rd_adr < NB_BRIQUES) ? alive[rd_adr] : 0.
  - A read of the index written in the same edge returns the old value.

## Timing
- Kill: adr_brique changes before edge k, and the request is captured at edge k. In IDLE, the bit is cleared and the count updated at edge k+1. brique_cassee/niveau_fini are high from k+1 to k+2.
- Init: init_niveau sampled at edge k. Bit i is set at edge k+1+i. occupe is high from edge k to edge k+NB_BRIQUES. A kill pending at the end is applied at edge k+NB_BRIQUES+1.
- Read latency: 1 cycle, fully pipelined, one query per cycle.
- Mid-operation reset: asynchronous return to the reset values; the sweep is abandoned and the pending kill is lost.

## Structure
- Package brique_pkg:
  - ADR_W = 9
  - ADR_IDLE = 9'h1FF
  - state type {IDLE, INIT}
- Sub-module brique_bitmap: NB_BRIQUES x 1-bit memory.
  - One synchronous write port: we, wadr, wdata.
  - One synchronous read port.
  - One combinational read of the kill index, used to test alive-before-clear.
- Top level holds: change detector, pending register, FSM, init counter, remaining-count counter.

## Test plan
- Reset, then init_niveau with NB_BRIQUES=400 -> occupe high for 400 cycles; nb_restantes 0 -> 400; a sweep of rd_adr 0..399 returns 1 and rd_adr 400 returns 0.
- After init, adr_brique 0 -> 9'h1FF -> 5 -> nb_restantes 399, alive[5]=0, exactly one brique_cassee pulse at edge k+1.
- Write 5, then 9'h1FF, then 5 again -> second kill gives no pulse and no count change. Write 450 -> ignored.
- NB_BRIQUES=3: init, then kill 0, 1, 2 -> niveau_fini pulses together with the third brique_cassee; nb_restantes = 0.
- Kill 7 issued while occupe -> applied on the first IDLE cycle after the sweep: nb_restantes = NB_BRIQUES-1. Kill and init_niveau in the same cycle -> kill flushed, nb_restantes = NB_BRIQUES.
- reset_n asserted mid-sweep (i=200) -> all outputs at reset values immediately; rd_vivante 0 for every index afterwards.
